// File: rtl/key_pkg.sv
// Shared definitions for the multi-key debounce block.
//   key_state_e : per-channel FSM encoding (also published on the debug bus)
//   cnt_width() : counter width helper, never narrower than 1 bit
package key_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } key_state_e;

    localparam int unsigned STATE_W = 2;

    // Bits needed to count 0..n-1, with a floor of 1 so a disabled or
    // trivially small counter still has a legal vector width.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/multi_key_debounce_if.sv
// Bundle of the key pins, conditioned outputs and FSM debug state.
//   slave  : the debounce block (reads Pin_In, drives everything else)
//   master : whoever owns the pins and consumes the key events
// Handshake: none. Pin_In is a free-running level; Key_State is a level;
// Press_Pulse, Release_Pulse and Long_Pulse are single-cycle strobes that
// the consumer must sample on every CLK edge (there is no ready/back-pressure).
interface multi_key_debounce_if #(
    parameter int unsigned N_KEYS = 4
);
    logic [N_KEYS-1:0]   Pin_In;
    logic [N_KEYS-1:0]   Key_State;
    logic [N_KEYS-1:0]   Press_Pulse;
    logic [N_KEYS-1:0]   Release_Pulse;
    logic [N_KEYS-1:0]   Long_Pulse;
    // channel i FSM state lives in fsm_state[2*i +: 2] (key_state_e encoding)
    logic [2*N_KEYS-1:0] fsm_state;

    modport master (
        output Pin_In,
        input  Key_State, Press_Pulse, Release_Pulse, Long_Pulse, fsm_state
    );

    modport slave (
        input  Pin_In,
        output Key_State, Press_Pulse, Release_Pulse, Long_Pulse, fsm_state
    );
endinterface

// File: rtl/key_channel.sv
// One key channel: 2-flop synchroniser, debounce FSM, long-press counter.
//   CLK, RST      : clock, synchronous active-high reset
//   pin_in        : raw asynchronous key pin
//   key_state     : debounced level, 1 = pressed
//   press_pulse   : 1-cycle strobe on accepted press
//   release_pulse : 1-cycle strobe on accepted release
//   long_pulse    : 1-cycle strobe once per press after the long hold time
//   fsm_state     : current FSM state (debug)
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         pin_in,
    output logic         key_state,
    output logic         press_pulse,
    output logic         release_pulse,
    output logic         long_pulse,
    output logic [1:0]   fsm_state
);

    localparam int unsigned DB_W = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned LC_W = cnt_width(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    // The press-pulse cycle is already the first held cycle, so the long
    // strobe fires when the counter (cleared on that edge) reaches LONG-2.
    localparam int unsigned LONG_HIT_I = (LONG_CYCLES >= 2) ? LONG_CYCLES - 2 : 0;
    localparam logic [LC_W-1:0] LONG_HIT = LC_W'(LONG_HIT_I);
    localparam bit   LONG_EN  = (LONG_CYCLES != 0);
    localparam logic IDLE_LVL = ACTIVE_LOW;

    logic            sync1, sync2;
    logic            p;
    key_state_e      state, state_n;
    logic [DB_W-1:0] cnt, cnt_n;
    logic [LC_W-1:0] lcnt, lcnt_n;
    logic            long_done, long_done_n;
    logic            press_n, release_n, long_n;

    // normalised level: 1 = pressed regardless of pin polarity
    assign p = sync2 ^ IDLE_LVL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1         <= IDLE_LVL;
            sync2         <= IDLE_LVL;
            state         <= IDLE;
            cnt           <= '0;
            lcnt          <= '0;
            long_done     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
        end else begin
            sync1         <= pin_in;
            sync2         <= sync1;
            state         <= state_n;
            cnt           <= cnt_n;
            lcnt          <= lcnt_n;
            long_done     <= long_done_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lcnt_n      = lcnt;
        long_done_n = long_done;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;

        case (state)
            IDLE: begin
                if (p) begin
                    state_n = DB_PRESS;
                    cnt_n   = '0;
                end
            end
            DB_PRESS: begin
                if (!p) begin
                    state_n = IDLE;
                end else if (cnt == DB_LAST) begin
                    state_n     = HELD;
                    press_n     = 1'b1;
                    lcnt_n      = '0;
                    long_done_n = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_n = DB_REL;
                    cnt_n   = '0;
                end
            end
            DB_REL: begin
                if (p) begin
                    state_n = HELD;
                end else if (cnt == DB_LAST) begin
                    state_n   = IDLE;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Long-press counting runs through release bounces. It is skipped
        // on the edge that accepts a release so the two strobes never meet.
        if (LONG_EN && !long_done && !release_n &&
            (state == HELD || state == DB_REL)) begin
            if (lcnt == LONG_HIT) begin
                long_n      = 1'b1;
                long_done_n = 1'b1;
            end else begin
                lcnt_n = lcnt + 1'b1;
            end
        end
    end

    assign key_state = (state == HELD) || (state == DB_REL);
    assign fsm_state = state;

endmodule

// File: rtl/multi_key_debounce.sv
// N-channel push-button conditioner. Each channel is an independent
// key_channel; this level only replicates them and packs the vectors.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : multi_key_debounce_if slave (Pin_In in; Key_State,
//              Press_Pulse, Release_Pulse, Long_Pulse, fsm_state out)
module multi_key_debounce #(
    parameter int unsigned N_KEYS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                CLK,
    input  logic                RST,
    multi_key_debounce_if.slave bus
);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .CLK           (CLK),
            .RST           (RST),
            .pin_in        (bus.Pin_In[i]),
            .key_state     (bus.Key_State[i]),
            .press_pulse   (bus.Press_Pulse[i]),
            .release_pulse (bus.Release_Pulse[i]),
            .long_pulse    (bus.Long_Pulse[i]),
            .fsm_state     (bus.fsm_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench: two instances (active-low and active-high pins),
// N_KEYS=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=10. Edge k below means the k-th
// rising edge after the pin change; outputs are sampled 1 ns after it.
module tb_multi_key_debounce;

    localparam int unsigned N  = 2;
    localparam int unsigned DB = 4;
    localparam int unsigned LG = 10;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_key_debounce_if #(.N_KEYS(N)) bus_a ();
    multi_key_debounce_if #(.N_KEYS(N)) bus_b ();

    multi_key_debounce #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .CLK(clk), .RST(rst), .bus(bus_a.slave)
    );

    multi_key_debounce #(
        .N_KEYS(N), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LG), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .CLK(clk), .RST(rst), .bus(bus_b.slave)
    );

    // scoreboard
    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release channel 0 of dut_a (pin back high) and check the release path.
    task automatic rel_a(input string tag);
        bus_a.Pin_In[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            chk({tag, "_rel"},  32'(bus_a.Release_Pulse[0]), 32'(j == 6));
            chk({tag, "_key"},  32'(bus_a.Key_State[0]),     32'(j < 6));
            chk({tag, "_long"}, 32'(bus_a.Long_Pulse[0]),    32'd0);
        end
        chk({tag, "_idle"}, 32'(bus_a.fsm_state[1:0]), 32'd0);
    endtask

    initial begin
        bus_a.Pin_In = 2'b11;
        bus_b.Pin_In = 2'b00;
        rst = 1'b1;
        step();
        step();

        // reset state
        chk("rst_key_a",   32'(bus_a.Key_State),   32'd0);
        chk("rst_press_a", 32'(bus_a.Press_Pulse), 32'd0);
        chk("rst_fsm_a",   32'(bus_a.fsm_state),   32'd0);
        chk("rst_key_b",   32'(bus_b.Key_State),   32'd0);
        chk("rst_press_b", 32'(bus_b.Press_Pulse), 32'd0);
        rst = 1'b0;
        step();
        step();

        // clean press on ch0 (both polarities), held into long press
        for (int k = 0; k < 10; k++) exp_q.push_back((k == 6) ? 2'b01 : 2'b00);
        bus_a.Pin_In[0] = 1'b0;
        bus_b.Pin_In[0] = 1'b1;
        for (int k = 0; k < 26; k++) begin
            logic [1:0] ep;
            step();
            ep = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
            chk("s1_press_a", 32'(bus_a.Press_Pulse), 32'(ep));
            chk("s1_press_b", 32'(bus_b.Press_Pulse), 32'(ep));
            chk("s1_key_a",   32'(bus_a.Key_State),   32'(k >= 6));
            chk("s1_key_b",   32'(bus_b.Key_State),   32'(k >= 6));
            chk("s1_long_a",  32'(bus_a.Long_Pulse),  32'(k == 15));
            chk("s1_long_b",  32'(bus_b.Long_Pulse),  32'(k == 15));
            chk("s1_rel_a",   32'(bus_a.Release_Pulse), 32'd0);
        end
        bus_a.Pin_In[0] = 1'b1;
        bus_b.Pin_In[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("s3_rel_a",  32'(bus_a.Release_Pulse), 32'(j == 6));
            chk("s3_rel_b",  32'(bus_b.Release_Pulse), 32'(j == 6));
            chk("s3_key_a",  32'(bus_a.Key_State),     32'(j < 6));
            chk("s3_key_b",  32'(bus_b.Key_State),     32'(j < 6));
            chk("s3_long_a", 32'(bus_a.Long_Pulse),    32'd0);
        end

        // press bounce shorter than the window
        bus_a.Pin_In[0] = 1'b0;
        step();
        step();
        step();
        bus_a.Pin_In[0] = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            chk("s2_press", 32'(bus_a.Press_Pulse), 32'd0);
            chk("s2_key",   32'(bus_a.Key_State),   32'd0);
            chk("s2_rel",   32'(bus_a.Release_Pulse), 32'd0);
        end
        chk("s2_idle", 32'(bus_a.fsm_state[1:0]), 32'd0);

        // release bounce while held
        bus_a.Pin_In[0] = 1'b0;
        for (int k = 0; k < 21; k++) begin
            step();
            chk("s4_press", 32'(bus_a.Press_Pulse[0]),   32'(k == 6));
            chk("s4_key",   32'(bus_a.Key_State[0]),     32'(k >= 6));
            chk("s4_rel",   32'(bus_a.Release_Pulse[0]), 32'd0);
            chk("s4_long",  32'(bus_a.Long_Pulse[0]),    32'(k == 15));
            if (k >= 11 && k <= 13)
                chk("s4_fsm", 32'(bus_a.fsm_state[1:0]), (k == 13) ? 32'd2 : 32'd3);
            if (k == 8)  bus_a.Pin_In[0] = 1'b1;
            if (k == 10) bus_a.Pin_In[0] = 1'b0;
        end
        rel_a("s4");

        // reset while debouncing a press
        bus_a.Pin_In[0] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        chk("s5_dbpress", 32'(bus_a.fsm_state[1:0]), 32'd1);
        rst = 1'b1;
        step();
        chk("s5_rst_key",   32'(bus_a.Key_State),     32'd0);
        chk("s5_rst_press", 32'(bus_a.Press_Pulse),   32'd0);
        chk("s5_rst_rel",   32'(bus_a.Release_Pulse), 32'd0);
        chk("s5_rst_fsm",   32'(bus_a.fsm_state),     32'd0);
        rst = 1'b0;
        for (int j = 0; j < 9; j++) begin
            step();
            chk("s5_press", 32'(bus_a.Press_Pulse[0]), 32'(j == 6));
            chk("s5_key",   32'(bus_a.Key_State[0]),   32'(j >= 6));
        end
        rel_a("s5");

        // both channels pressed on the same edge
        bus_a.Pin_In = 2'b00;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("s6_press", 32'(bus_a.Press_Pulse), (k == 6) ? 32'd3 : 32'd0);
            chk("s6_key",   32'(bus_a.Key_State),   (k >= 6) ? 32'd3 : 32'd0);
        end
        bus_a.Pin_In = 2'b11;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("s6_rel", 32'(bus_a.Release_Pulse), (j == 6) ? 32'd3 : 32'd0);
            chk("s6_key_rel", 32'(bus_a.Key_State), (j < 6) ? 32'd3 : 32'd0);
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
